// File: rtl/shift_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_sched_if
// Description : Requester handshakes, divider input and shift-register
//               controls of the shift frame scheduler.
// Revision    : 1.0  initial release
// ============================================================================
interface shift_frame_sched_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
);
    logic [DIV_W-1:0]  div;
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              sr_load;
    logic              sr_enable;
    logic [DATA_W-1:0] sr_data;
    logic              sr_fill;
    logic              busy;
    logic              grant;
    logic              frame_done;

    modport master (
        output div, req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sr_load, sr_enable, sr_data,
               sr_fill, busy, grant, frame_done
    );

    modport slave (
        input  div, req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sr_load, sr_enable, sr_data,
               sr_fill, busy, grant, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/shift_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : shift_frame_sched
// Description : Round-robin scheduler sharing one parallel-load shift
//               register between two byte requesters.
// Revision    : 1.0  initial release
// ============================================================================
module shift_frame_sched #(
    parameter int   DATA_W   = 8,
    parameter int   DIV_W    = 8,
    parameter logic FILL_BIT = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    shift_frame_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int                 c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    state_t             r_state;
    logic [DIV_W-1:0]   r_div_lat;
    logic [DIV_W-1:0]   r_divcnt;
    logic [c_cnt_w-1:0] r_bitcnt;
    logic               r_last_grant;
    logic               r_grant;
    logic [DATA_W-1:0]  r_sr_data;
    logic               r_sr_load;
    logic               r_sr_enable;
    logic               r_busy;
    logic               r_frame_done;

    logic w_idle;
    logic w_pick1;
    logic w_ready0;
    logic w_ready1;

    // On a tie the requester that did not own the previous frame wins
    assign w_idle   = (r_state == S_IDLE);
    assign w_pick1  = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_ready0 = w_idle && bus.req0_valid && !w_pick1;
    assign w_ready1 = w_idle && w_pick1;

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.sr_load    = r_sr_load;
    assign bus.sr_enable  = r_sr_enable;
    assign bus.sr_data    = r_sr_data;
    assign bus.sr_fill    = FILL_BIT;
    assign bus.busy       = r_busy;
    assign bus.grant      = r_grant;
    assign bus.frame_done = r_frame_done;

    // r_sr_enable is precomputed one cycle ahead so it is high exactly in the
    // SHIFT cycles where the divider count sits at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_div_lat    <= '0;
            r_divcnt     <= '0;
            r_bitcnt     <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_sr_data    <= '0;
            r_sr_load    <= 1'b0;
            r_sr_enable  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_sr_data    <= w_ready1 ? bus.req1_data : bus.req0_data;
                        r_grant      <= w_ready1;
                        r_last_grant <= w_ready1;
                        r_sr_load    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sr_load   <= 1'b0;
                    r_div_lat   <= bus.div;
                    r_divcnt    <= bus.div;
                    r_bitcnt    <= '0;
                    r_sr_enable <= (bus.div == '0);
                    r_state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_divcnt == '0) begin
                        r_divcnt <= r_div_lat;
                        r_bitcnt <= r_bitcnt + c_cnt_w'(1);
                        if (r_bitcnt == c_last_bit) begin
                            r_sr_enable  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_sr_enable <= (r_div_lat == '0);
                        end
                    end else begin
                        r_divcnt    <= r_divcnt - DIV_W'(1);
                        r_sr_enable <= (r_divcnt == DIV_W'(1));
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shift_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_frame_sched
// Description : Directed + randomized bench for shift_frame_sched against a
//               frame-timing reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_frame_sched;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_frame_sched_if #(.DATA_W(8), .DIV_W(8)) bus ();

    shift_frame_sched #(.DATA_W(8), .DIV_W(8), .FILL_BIT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a frame is described by its handshake cycle and bit period
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         t = 0;
    int         fr_T = -1;
    int         fr_d = 0;
    bit         d_known = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_grant = 1'b0;
    logic       last_g = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        int ph;
        if (fr_T < 0) return 0;
        ph = t - fr_T;
        return (ph >= 1) && (!d_known || ph <= 2 + DW * (fr_d + 1));
    endfunction

    task automatic model_reset();
        fr_T = -1; d_known = 0; exp_data = 8'h00; exp_grant = 1'b0; last_g = 1'b1;
    endtask

    task automatic drive();
        bus.req0_valid = (q0.size() > 0);
        bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'($urandom);
        bus.req1_valid = (q1.size() > 0);
        bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'($urandom);
    endtask

    task automatic cycle();
        int   ph;
        bit   bsy, e_load, e_en, e_done, winner, r0, r1;
        @(negedge clk);
        ph     = (fr_T < 0) ? -1 : t - fr_T;
        bsy    = model_busy();
        e_load = (ph == 1);
        e_en   = d_known && ph >= 2 && ((ph - 1) % (fr_d + 1) == 0)
                 && ((ph - 1) / (fr_d + 1) <= DW);
        e_done = d_known && (ph == 2 + DW * (fr_d + 1));
        if (bus.req0_valid && bus.req1_valid) winner = !last_g;
        else                                  winner = bus.req1_valid;
        r0 = !bsy && bus.req0_valid && !winner;
        r1 = !bsy && bus.req1_valid && winner;
        chk("req0_ready", bus.req0_ready, r0);
        chk("req1_ready", bus.req1_ready, r1);
        chk("sr_load", bus.sr_load, e_load);
        chk("sr_enable", bus.sr_enable, e_en);
        chk("frame_done", bus.frame_done, e_done);
        chk("busy", bus.busy, bsy);
        chk("sr_data", bus.sr_data, exp_data);
        chk("grant", bus.grant, exp_grant);
        chk("sr_fill", bus.sr_fill, 1'b1);
        if (rst_n && ph == 1) begin
            fr_d    = int'(bus.div);
            d_known = 1;
        end
        if (rst_n && (r0 || r1)) begin
            fr_T      = t;
            d_known   = 0;
            exp_data  = r1 ? q1[0] : q0[0];
            exp_grant = r1;
            last_g    = r1;
            if (r1) void'(q1.pop_front());
            else    void'(q0.pop_front());
        end
        t++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || model_busy()) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (n < budget), 1'b1);
        repeat (2) cycle();
    endtask

    task automatic run_to_phase(input int ph, input int budget);
        int n = 0;
        while (!(fr_T >= 0 && t - fr_T == ph) && n < budget) begin
            cycle();
            n++;
        end
        chk("phase_timeout", (n < budget), 1'b1);
    endtask

    initial begin
        bus.div = 8'd0;
        model_reset();
        drive();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single requester, div=0
        bus.div = 8'd0;
        q0.push_back(8'hA5);
        drain(100);

        // Both requesters contending: grants alternate
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'h11);
            q1.push_back(8'h22);
        end
        bus.div = 8'd1;
        drain(400);

        // div=3 frame
        bus.div = 8'd3;
        q1.push_back(8'($urandom));
        drain(200);

        // div change mid-frame only affects the next frame
        bus.div = 8'd3;
        q0.push_back(8'($urandom));
        run_to_phase(12, 50);
        bus.div = 8'd0;
        q0.push_back(8'($urandom));
        drain(200);

        // Async reset after the third enable
        bus.div = 8'd0;
        q0.push_back(8'h5A);
        q1.push_back(8'hC3);
        q0.push_back(8'h3C);
        run_to_phase(5, 50);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_sr_load", bus.sr_load, 1'b0);
        chk("rst_sr_enable", bus.sr_enable, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_sr_data", bus.sr_data, 8'h00);
        chk("rst_grant", bus.grant, 1'b0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        drain(300);

        // req1 alone, back-to-back
        bus.div = 8'($urandom_range(0, 2));
        for (int i = 0; i < 4; i++) q1.push_back(8'($urandom));
        drain(400);

        // Randomized traffic and divider changes
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) != 0) q0.push_back(8'($urandom));
            if ($urandom_range(0, 1) != 0) q1.push_back(8'($urandom));
            bus.div = 8'($urandom_range(0, 4));
            repeat ($urandom_range(0, 40)) cycle();
        end
        drain(2000);

        // Maximum divider
        bus.div = 8'hFF;
        q1.push_back(8'($urandom));
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
